// File: rtl/hazard_pkg.sv
// Shared types for the hazard unit: forward-select encoding, shadow pipeline entry, x0 constant.
package hazard_pkg;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       is_load;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } hz_entry_t;

    // True when entry e will write register rs (x0 never counts as a producer)
    function automatic logic writes_reg(hz_entry_t e, logic [4:0] rs);
        return e.valid && e.reg_write && (e.rd != REG_X0) && (e.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Decode/execute hazard signals; slave is the hazard unit, master is the pipeline driving it.
interface hazard_unit_if #(parameter int CNT_W = 32);
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       RdD;
    logic             RegWriteD;
    logic [1:0]       ResultSrcD;
    logic             PCSrcE;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport slave (
        input  Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, StallCount, FlushCount
    );

    modport master (
        output Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_fwd_match.sv
// Forward select for one execute operand: memory-stage producer wins over writeback.
module hazard_fwd_match
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       e_valid,
    input  hz_entry_t  m_ent,
    input  hz_entry_t  w_ent,
    output fwd_sel_t   sel
);

    always_comb begin
        sel = FWD_RF;
        if (e_valid) begin
            if (writes_reg(m_ent, rs))      sel = FWD_MEM;
            else if (writes_reg(w_ent, rs)) sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit: shadow E/M/W pipeline, load-use stall, branch flush, operand forwarding.
// Optional saturating stall/flush counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter logic [1:0] LOAD_SRC = 2'b01,
    parameter int         CNT_W    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_unit_if.slave  hif
);

    hz_entry_t e_q, e_d, m_q, m_d, w_q, w_d;
    logic      load_use;
    logic      stall;
    logic      flush_d;
    logic      flush_e;
    fwd_sel_t  fwd_a, fwd_b;

    always_comb begin
        load_use = e_q.valid && e_q.is_load && e_q.reg_write && (e_q.rd != REG_X0) &&
                   ((e_q.rd == hif.Rs1D) || (e_q.rd == hif.Rs2D));
        // Gating with rst_n drops a pending stall/flush the moment reset asserts
        stall    = rst_n && load_use && !hif.PCSrcE;
        flush_d  = rst_n && hif.PCSrcE;
        flush_e  = rst_n && (hif.PCSrcE || load_use);
    end

    always_comb begin
        w_d = m_q;
        m_d = e_q;
        e_d = '0;
        if (!flush_e) begin
            e_d.valid     = 1'b1;
            e_d.rd        = hif.RdD;
            e_d.reg_write = hif.RegWriteD;
            e_d.is_load   = (hif.ResultSrcD == LOAD_SRC);
            e_d.rs1       = hif.Rs1D;
            e_d.rs2       = hif.Rs2D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    hazard_fwd_match u_fwd_a (.rs(e_q.rs1), .e_valid(e_q.valid), .m_ent(m_q), .w_ent(w_q), .sel(fwd_a));
    hazard_fwd_match u_fwd_b (.rs(e_q.rs2), .e_valid(e_q.valid), .m_ent(m_q), .w_ent(w_q), .sel(fwd_b));

    assign hif.StallF    = stall;
    assign hif.StallD    = stall;
    assign hif.FlushD    = flush_d;
    assign hif.FlushE    = flush_e;
    assign hif.ForwardAE = fwd_a;
    assign hif.ForwardBE = fwd_b;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1))         stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (hif.PCSrcE && (flush_cnt_q != '1))    flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hif.StallCount = stall_cnt_q;
    assign hif.FlushCount = flush_cnt_q;
`else
    assign hif.StallCount = '0;
    assign hif.FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized + directed bench for hazard_unit against an instruction-level pipeline model.
module tb_hazard_unit;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_unit_if #(.CNT_W(CW)) hif();
    hazard_unit #(.LOAD_SRC(2'b01), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .hif(hif.slave));

    // Model: pipe[0]=execute, pipe[1]=memory, pipe[2]=writeback
    typedef struct {
        bit v; int rd; bit rw; bit ld; int rs1; int rs2;
    } ins_t;
    ins_t pipe[3];
    int   exp_sc, exp_fc;
    int   n_chk, n_pass;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, act, exp);
    endtask

    function automatic int fwd(input int rs);
        if (!pipe[0].v) return 0;
        for (int k = 1; k <= 2; k++)
            if (pipe[k].v && pipe[k].rw && pipe[k].rd != 0 && pipe[k].rd == rs)
                return (k == 1) ? 2 : 1;
        return 0;
    endfunction

    function automatic bit lu();
        return pipe[0].v && pipe[0].ld && pipe[0].rw && pipe[0].rd != 0 &&
               (pipe[0].rd == int'(hif.Rs1D) || pipe[0].rd == int'(hif.Rs2D));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0, 0, 0};
        exp_sc = 0;
        exp_fc = 0;
    endtask

    task automatic drive(input int rs1, input int rs2, input int rd, input bit rw, input int src, input bit pc);
        hif.Rs1D       = 5'(rs1);
        hif.Rs2D       = 5'(rs2);
        hif.RdD        = 5'(rd);
        hif.RegWriteD  = rw;
        hif.ResultSrcD = 2'(src);
        hif.PCSrcE     = pc;
    endtask

    task automatic check_outs(input string tag);
        bit r, pc, l;
        r  = (rst_n === 1'b1);
        pc = hif.PCSrcE;
        l  = lu();
        chk({tag, ".StallF"}, int'(hif.StallF), int'(r && l && !pc));
        chk({tag, ".StallD"}, int'(hif.StallD), int'(r && l && !pc));
        chk({tag, ".FlushD"}, int'(hif.FlushD), int'(r && pc));
        chk({tag, ".FlushE"}, int'(hif.FlushE), int'(r && (pc || l)));
        chk({tag, ".FwdA"}, int'(hif.ForwardAE), r ? fwd(pipe[0].rs1) : 0);
        chk({tag, ".FwdB"}, int'(hif.ForwardBE), r ? fwd(pipe[0].rs2) : 0);
        chk({tag, ".SCnt"}, int'(hif.StallCount), exp_sc);
        chk({tag, ".FCnt"}, int'(hif.FlushCount), exp_fc);
    endtask

    // Check at negedge+1, then advance one clock with the same inputs
    task automatic step(input string tag);
        bit st, pc, l;
        #1;
        check_outs(tag);
        pc = hif.PCSrcE;
        l  = lu();
        st = l && !pc;
        @(posedge clk);
        if (rst_n) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (pc || l) pipe[0] = '{0, 0, 0, 0, 0, 0};
            else pipe[0] = '{1, int'(hif.RdD), hif.RegWriteD, hif.ResultSrcD == 2'b01,
                             int'(hif.Rs1D), int'(hif.Rs2D)};
`ifdef HAZARD_PERF_CNT_EN
            if (st && exp_sc < 15) exp_sc++;
            if (pc && exp_fc < 15) exp_fc++;
`endif
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        nop();
        @(negedge clk);
        do_reset();

        // lw x5; add x6,x5,x1 -> one stall, then writeback forward
        drive(0, 0, 5, 1, 1, 0); step("lw");
        drive(5, 1, 6, 1, 0, 0); #1 chk("ldu.stall", int'(hif.StallD), 1); step("ldu1");
        step("ldu2");
        nop(); #1 chk("ldu.fwdA", int'(hif.ForwardAE), 1); step("ldu3");

        // add x3; sub x4,x3,x3 back-to-back then with a nop between
        drive(1, 2, 3, 1, 0, 0); step("add3");
        drive(3, 3, 4, 1, 0, 0); step("sub");
        nop(); #1 chk("b2b.fwdA", int'(hif.ForwardAE), 2); chk("b2b.fwdB", int'(hif.ForwardBE), 2); step("b2b");
        drive(1, 2, 3, 1, 0, 0); step("add3b");
        nop(); step("gap");
        drive(3, 3, 4, 1, 0, 0); step("subb");
        nop(); #1 chk("gap.fwdA", int'(hif.ForwardAE), 1); chk("gap.fwdB", int'(hif.ForwardBE), 1); step("gapchk");

        // x7 in both M and W: memory wins
        drive(0, 0, 7, 1, 0, 0); step("w7a");
        drive(0, 0, 7, 1, 0, 0); step("w7b");
        drive(7, 0, 8, 1, 0, 0); step("r7");
        nop(); #1 chk("prio.fwdA", int'(hif.ForwardAE), 2); step("prio");

        // load-use coinciding with a redirect: flush wins
        drive(0, 0, 5, 1, 1, 0); step("lw2");
        drive(5, 0, 6, 1, 0, 1); #1 chk("br.FlushD", int'(hif.FlushD), 1); chk("br.StallD", int'(hif.StallD), 0);
        step("br");

        // x0 never stalls or forwards
        drive(0, 0, 0, 1, 1, 0); step("lwx0");
        drive(0, 0, 1, 1, 0, 0); #1 chk("x0.stall", int'(hif.StallD), 0); step("x0a");
        nop(); #1 chk("x0.fwdA", int'(hif.ForwardAE), 0); step("x0b");

        // reset asserted mid-stall clears outputs without a clock edge
        drive(0, 0, 5, 1, 1, 0); step("lw3");
        drive(5, 5, 6, 1, 0, 0); #1 chk("rst.pre", int'(hif.StallF), 1);
        hif.PCSrcE = 1'b1;
        do_reset();

        // every-other-cycle load-use, 20+ stalls saturate the 4-bit counter
        drive(5, 5, 5, 1, 1, 0);
        for (int i = 0; i < 44; i++) step("sat");
        #1;
`ifdef HAZARD_PERF_CNT_EN
        chk("sat.StallCount", int'(hif.StallCount), 15);
`else
        chk("sat.StallCount", int'(hif.StallCount), 0);
`endif

        // random traffic over a small register set so hazards are common
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 7) == 0);
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter LOAD_SRC, default 2'b01: ResultSrcD encoding that marks a load.
REQ-002 Parameter CNT_W, default 32: width of the performance counters.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 Rs1D, Rs2D  in  5 each  decode-stage source registers.
REQ-006 RdD  in  5  decode-stage destination register.
REQ-007 RegWriteD  in  1  decode instruction writes the register file.
REQ-008 ResultSrcD  in  2  decode result source.
REQ-009 PCSrcE  in  1  execute stage redirects the PC (taken branch or jump).
REQ-010 StallF, StallD  out  1 each  hold the PC register and the F/D register.
REQ-011 FlushD, FlushE  out  1 each  bubble the F/D and D/E registers.
REQ-012 ForwardAE, ForwardBE  out  2 each  execute operand select: 00 register file, 01 writeback, 10 memory.
REQ-013 StallCount, FlushCount  out  CNT_W each  performance counters.

Function
REQ-014 The unit SHALL keep a shadow pipeline of three entries, E, M and W. Each entry holds {valid, Rd, RegWrite, isLoad, Rs1, Rs2}.
REQ-015 Each cycle: W<=M; M<=E; E<=decode fields, where isLoad=(ResultSrcD==LOAD_SRC).
REQ-016 When FlushE=1, E SHALL load an invalid entry instead, and M/W SHALL still advance.
REQ-017 Load-use condition: E.valid, E.isLoad, E.RegWrite, E.Rd!=0, and E.Rd equals Rs1D or Rs2D.
REQ-018 On the load-use condition with PCSrcE=0, the unit SHALL drive StallF=StallD=FlushE=1 and FlushD=0, for exactly one cycle per load.
REQ-019 PCSrcE=1 SHALL drive FlushD=FlushE=1 and StallF=StallD=0. This overrides a simultaneous load-use condition.
REQ-020 Otherwise StallF, StallD, FlushD and FlushE SHALL be 0.
REQ-021 ForwardAE SHALL be 10 when M.valid, M.RegWrite, M.Rd!=0 and M.Rd==E.Rs1.
REQ-022 Failing REQ-021, ForwardAE SHALL be 01 on the same conditions evaluated against W; otherwise 00.
REQ-023 ForwardBE SHALL follow REQ-021/022 using E.Rs2. M SHALL take priority over W.
REQ-024 Forwarding SHALL be 00 whenever E is invalid.
REQ-025 Stall and flush outputs SHALL be combinational from the current state and inputs, with zero-cycle latency. Forward selects SHALL depend only on registered state.
REQ-026 Register x0 SHALL never produce a stall or a forward.

Reset
REQ-027 While rst_n=0, all shadow entries SHALL be invalid, all counters 0, and every stall, flush and forward output 0.
REQ-028 An assertion of rst_n mid-stall SHALL clear the pending stall immediately, without waiting for a clock edge.
REQ-029 The first clk edge after deassertion SHALL resume normal shifting.

Configuration
REQ-030 With HAZARD_PERF_CNT_EN defined:
- StallCount SHALL increment on each cycle with StallD=1.
- FlushCount SHALL increment on each cycle with PCSrcE=1.
- Both SHALL saturate at all-ones.
REQ-031 Without HAZARD_PERF_CNT_EN, the ports SHALL remain and be tied to 0, with no counter flops.

Structure
REQ-032 Package hazard_pkg SHALL hold:
- enum fwd_sel_t: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- struct hz_entry_t holding the REQ-014 fields.
- constant REG_X0=5'd0.
REQ-033 One sub-module, hazard_fwd_match, SHALL compute a single operand's forward select from E.RsX, M and W. It SHALL be instantiated twice.

Verification
REQ-034 lw x5 then add x6,x5,x1 on consecutive cycles -> StallF=StallD=FlushE=1 for one cycle; then ForwardAE=01 when the add is in E.
REQ-035 add x3,x1,x2 then sub x4,x3,x3 -> ForwardAE=ForwardBE=10 in the sub's E cycle. With one nop between them -> both 01.
REQ-036 Writes to x7 in both M and W, consumer reads x7 -> ForwardAE=10 (M priority).
REQ-037 Load-use and PCSrcE=1 in the same cycle -> FlushD=FlushE=1, StallF=StallD=0; with HAZARD_PERF_CNT_EN, StallCount unchanged.
REQ-038 lw x0 then add x1,x0,x0 -> no stall, forwards 00.
REQ-039 Drop rst_n during a load-use stall -> all outputs 0 immediately. With CNT_W=4 and the macro defined, 20 stall cycles -> StallCount=4'hF.
